// File: rtl/lot_lane_controller.sv
// Single-lane parking-lot gate sequencer: round-robin in/out grants, passage timeout, occupancy count.
// Optional build macro LOT_RESERVE_EN adds a vip input and a RESERVED block of spaces only vip drivers may use.
module lot_lane_controller #(
  parameter int CAPACITY = 16,
  parameter int CNT_W    = 5,
  parameter int TIMEOUT  = 200,
  parameter int TO_W     = 8
`ifdef LOT_RESERVE_EN
  ,
  parameter int RESERVED = 2
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_in,
  input  logic             req_out,
`ifdef LOT_RESERVE_EN
  input  logic             vip,
`endif
  input  logic             enter,
  input  logic             exit,
  output logic             open_in,
  output logic             open_out,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             timeout_err
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_GRANT_IN  = 2'd1;
  localparam logic [1:0] S_GRANT_OUT = 2'd2;
  localparam logic [1:0] S_CLEAR     = 2'd3;

  localparam logic DIR_IN  = 1'b0;
  localparam logic DIR_OUT = 1'b1;

  localparam logic [CNT_W-1:0] CAP_C     = CNT_W'(CAPACITY);
  localparam logic [TO_W-1:0]  TO_LAST_C = TO_W'(TIMEOUT - 1);

`ifdef LOT_RESERVE_EN
  // Clamp so an oversized reservation simply locks out non-vip entry.
  localparam int               RES_LIM   = CAPACITY - RESERVED;
  localparam logic [CNT_W-1:0] RES_LIM_C = CNT_W'((RES_LIM < 0) ? 0 : RES_LIM);
`endif

  logic [1:0]       r_state;
  logic             r_last_dir;
  logic [CNT_W-1:0] r_count;
  logic [TO_W-1:0]  r_timer;

  logic [1:0]       w_state_nxt;
  logic             w_last_dir_nxt;
  logic [CNT_W-1:0] w_count_nxt;
  logic [TO_W-1:0]  w_timer_nxt;
  logic             w_full;
  logic             w_empty;
  logic             w_elig_in;
  logic             w_elig_out;
  logic             w_timeout;

  assign w_full  = (r_count == CAP_C);
  assign w_empty = (r_count == '0);

`ifdef LOT_RESERVE_EN
  assign w_elig_in = req_in & (vip ? (r_count < CAP_C) : (r_count < RES_LIM_C));
`else
  assign w_elig_in = req_in & ~w_full;
`endif
  assign w_elig_out = req_out & ~w_empty;

  // Expiry is suppressed when the matching passage arrives in the same cycle.
  always_comb begin
    w_timeout = 1'b0;
    if (r_timer == TO_LAST_C) begin
      if (r_state == S_GRANT_IN)  w_timeout = ~enter;
      if (r_state == S_GRANT_OUT) w_timeout = ~exit;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_last_dir_nxt = r_last_dir;
    w_timer_nxt    = '0;
    case (r_state)
      S_IDLE: begin
        if (w_elig_in && (!w_elig_out || r_last_dir == DIR_OUT)) begin
          w_state_nxt    = S_GRANT_IN;
          w_last_dir_nxt = DIR_IN;
        end else if (w_elig_out) begin
          w_state_nxt    = S_GRANT_OUT;
          w_last_dir_nxt = DIR_OUT;
        end
      end
      S_GRANT_IN: begin
        if (enter || w_timeout) w_state_nxt = S_CLEAR;
        else                    w_timer_nxt = r_timer + TO_W'(1);
      end
      S_GRANT_OUT: begin
        if (exit || w_timeout) w_state_nxt = S_CLEAR;
        else                   w_timer_nxt = r_timer + TO_W'(1);
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Occupancy tracks every passage regardless of grant direction.
  always_comb begin
    w_count_nxt = r_count;
    if (enter && !exit && !w_full)
      w_count_nxt = r_count + CNT_W'(1);
    else if (exit && !enter && !w_empty)
      w_count_nxt = r_count - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_last_dir <= DIR_OUT;
      r_count    <= '0;
      r_timer    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_last_dir <= w_last_dir_nxt;
      r_count    <= w_count_nxt;
      r_timer    <= w_timer_nxt;
    end
  end

  assign open_in     = (r_state == S_GRANT_IN);
  assign open_out    = (r_state == S_GRANT_OUT);
  assign busy        = (r_state != S_IDLE);
  assign count       = r_count;
  assign full        = w_full;
  assign empty       = w_empty;
  assign timeout_err = w_timeout;

endmodule

// File: tb/tb_lot_lane_controller.sv
// Randomized bench for lot_lane_controller (CAPACITY=3, TIMEOUT=8) against a behavioural lane model.
module tb_lot_lane_controller;

  localparam int CAPACITY = 3;
  localparam int CNT_W    = 3;
  localparam int TIMEOUT  = 8;
  localparam int TO_W     = 4;
  localparam int RESERVED = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             req_in = 1'b0;
  logic             req_out = 1'b0;
  logic             vip = 1'b0;
  logic             enter = 1'b0;
  logic             exit = 1'b0;
  logic             open_in;
  logic             open_out;
  logic             busy;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             timeout_err;

  int n_checks = 0;
  int n_pass   = 0;

  // Lane model: who holds the lane, how long it has been held, and the car tally.
  int m_cars;
  int m_holder;     // 0 nobody, 1 inbound driver, 2 outbound driver
  int m_held;       // cycles the current holder has had the lane
  bit m_gap;        // arm-lowering cycle after a grant ends
  bit m_prefer_in;  // next tie goes to the inbound side

  lot_lane_controller #(
    .CAPACITY(CAPACITY),
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
`ifdef LOT_RESERVE_EN
    ,
    .RESERVED(RESERVED)
`endif
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_in     (req_in),
    .req_out    (req_out),
`ifdef LOT_RESERVE_EN
    .vip        (vip),
`endif
    .enter      (enter),
    .exit       (exit),
    .open_in    (open_in),
    .open_out   (open_out),
    .busy       (busy),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_cars      = 0;
    m_holder    = 0;
    m_held      = 0;
    m_gap       = 1'b0;
    m_prefer_in = 1'b1;
  endtask

  // One clock: drive inputs, compare outputs with the model, then advance the model.
  task automatic step(input bit rst, input bit ri, input bit ro, input bit v,
                      input bit en, input bit ex);
    bit expire;
    bit can_in;
    bit can_out;
    @(negedge clk);
    reset = rst; req_in = ri; req_out = ro; vip = v; enter = en; exit = ex;
    #1;
    expire = (m_holder == 1 && m_held == TIMEOUT - 1 && !en) ||
             (m_holder == 2 && m_held == TIMEOUT - 1 && !ex);
    check("open_in",     32'(open_in),     32'(m_holder == 1));
    check("open_out",    32'(open_out),    32'(m_holder == 2));
    check("busy",        32'(busy),        32'(m_holder != 0 || m_gap));
    check("count",       32'(count),       32'(m_cars));
    check("full",        32'(full),        32'(m_cars == CAPACITY));
    check("empty",       32'(empty),       32'(m_cars == 0));
    check("timeout_err", 32'(timeout_err), 32'(expire));

    if (rst) begin
      model_reset();
    end else begin
`ifdef LOT_RESERVE_EN
      can_in = ri && (v ? (m_cars < CAPACITY) : (m_cars < CAPACITY - RESERVED));
`else
      can_in = ri && (m_cars < CAPACITY);
`endif
      can_out = ro && (m_cars > 0);
      if (m_gap) begin
        m_gap = 1'b0;
      end else if (m_holder != 0) begin
        if ((m_holder == 1 && en) || (m_holder == 2 && ex) || expire) begin
          m_holder = 0;
          m_gap    = 1'b1;
        end else begin
          m_held++;
        end
      end else if (can_in && (!can_out || m_prefer_in)) begin
        m_holder = 1; m_held = 0; m_prefer_in = 1'b0;
      end else if (can_out) begin
        m_holder = 2; m_held = 0; m_prefer_in = 1'b1;
      end
      if (en && !ex && m_cars < CAPACITY) m_cars++;
      else if (ex && !en && m_cars > 0) m_cars--;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int pulse_pct;
    int req_pct;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    model_reset();

    // Single inbound passage.
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    idle(3);
    step(0, 0, 0, 0, 1, 0);
    idle(3);

    // Contended lane with a car inside: grants should alternate.
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 1, 0, 0, 0);
      step(0, 1, 1, 0, 0, 0);
      step(0, 1, 1, 0, k != 1, k == 1);
      step(0, 1, 1, 0, 0, 0);
    end
    idle(2);

    // Fill the lot, then a held entry request must be refused.
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 10; k++) step(0, 1, 0, 1, 0, 0);

    // Timeout on inbound, then matching pulse in the last cycle.
    step(0, 0, 0, 0, 0, 1);
    step(0, 1, 0, 1, 0, 0);
    idle(10);
    step(0, 1, 0, 1, 0, 0);
    idle(7);
    step(0, 0, 0, 0, 1, 0);
    idle(2);

    // Simultaneous pulses and underflow.
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 1);

    // Reset during an outbound grant, then reserved-space behaviour.
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 3; k++) step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0);
    idle(TIMEOUT + 3);

    // Random traffic in phases with varying pulse density so timeouts also occur.
    for (int ph = 0; ph < 60; ph++) begin
      pulse_pct = $urandom_range(0, 35);
      req_pct   = $urandom_range(20, 90);
      for (int c = 0; c < 50; c++)
        step($urandom_range(0, 299) == 0,
             $urandom_range(0, 99) < req_pct,
             $urandom_range(0, 99) < req_pct,
             $urandom_range(0, 1) == 1,
             $urandom_range(0, 99) < pulse_pct,
             $urandom_range(0, 99) < pulse_pct);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
